// File: rtl/vedic_mult_pipe_if.sv
// vedic_mult_pipe_if
//   Stream bundle for the pipelined Vedic multiplier: an operand channel and a
//   product channel, each with a valid/ready handshake.
//   Signals:
//     in_valid  / in_ready   operand beat handshake
//     in_a, in_b             WIDTH-bit operands
//     in_signed              1 = two's-complement beat, 0 = unsigned beat
//     out_valid / out_ready  product beat handshake
//     out_p                  2*WIDTH-bit product
//   master: operand source / product consumer side
//   slave : multiplier side
interface vedic_mult_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_p
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_p
    );
endinterface

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe
//   Three-stage pipelined WIDTH x WIDTH Urdhva-Tiryagbhyam multiplier with
//   per-beat signed/unsigned selection and full backpressure.
//     S1: capture operand magnitudes and the product sign
//     S2: four half-width partial products built from 2x2 Vedic cells
//     S3: ripple-carry accumulation and conditional two's-complement
//   Latency is 3 edges from input transfer to out_valid; throughput is one
//   beat per cycle while out_ready is high.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  stream bundle (slave modport): in_valid/in_ready/in_a/in_b/
//          in_signed, out_valid/out_ready/out_p
//   WIDTH must be a power of two and at least 4.
module vedic_mult_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    vedic_mult_pipe_if.slave   bus
);
    localparam int unsigned H  = WIDTH / 2;   // half operand width
    localparam int unsigned HP = 2 * H;       // half-width product width (== WIDTH)
    localparam int unsigned PW = 2 * WIDTH;   // full product width
    localparam int unsigned NC = H / 2;       // 2-bit digits per half operand

    // ------------------------------------------------------------------
    // Arithmetic building blocks
    // ------------------------------------------------------------------

    // 2x2 Vedic cell: vertical/crosswise ANDs folded with two half adders.
    function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
        logic t0, t1, t2, t3, c1;
        logic [3:0] p;
        t0   = x[0] & y[0];
        t1   = x[1] & y[0];
        t2   = x[0] & y[1];
        t3   = x[1] & y[1];
        p[0] = t0;
        p[1] = t1 ^ t2;
        c1   = t1 & t2;
        p[2] = t3 ^ c1;
        p[3] = t3 & c1;
        return p;
    endfunction

    // H x H product by recursive Vedic decomposition, unrolled bottom-up:
    // every 2-bit digit pair gets a 2x2 cell, then each level merges four
    // s/2-sized products into one s-sized product until one H x H remains.
    function automatic logic [HP-1:0] vedic_half(input logic [H-1:0] x,
                                                 input logic [H-1:0] y);
        logic [HP-1:0] cur [NC][NC];
        logic [HP-1:0] nxt [NC][NC];
        logic [HP-1:0] mid;
        int unsigned   n;
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NC; j++) begin
                cur[i][j] = HP'(mul2x2(x[2*i +: 2], y[2*j +: 2]));
                nxt[i][j] = '0;
            end
        end
        n = NC;
        for (int unsigned s = 4; s <= H; s = s * 2) begin
            n = n / 2;
            for (int unsigned i = 0; i < n; i++) begin
                for (int unsigned j = 0; j < n; j++) begin
                    // cur[row of x digit][row of y digit]; low index = low half
                    mid       = cur[2*i][2*j+1] + cur[2*i+1][2*j];
                    nxt[i][j] = cur[2*i][2*j] + (mid << (s / 2))
                              + (cur[2*i+1][2*j+1] << s);
                end
            end
            cur = nxt;
        end
        return cur[0][0];
    endfunction

    function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] x,
                                                 input logic [PW-1:0] y);
        logic [PW-1:0] s;
        logic          c;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    function automatic logic [PW-1:0] zext(input logic [HP-1:0] v);
        return {{(PW - HP){1'b0}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic               v1_q, neg1_q;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q;

    logic               v2_q, neg2_q;
    logic [HP-1:0]      p_ll_q, p_lh_q, p_hl_q, p_hh_q;

    logic               out_valid_q;
    logic [PW-1:0]      out_p_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;
    logic in_xfer;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign in_xfer      = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;

    // ------------------------------------------------------------------
    // S1 next-state: magnitudes and product sign
    // ------------------------------------------------------------------
    logic               a_neg, b_neg, neg_d;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d;

    always_comb begin
        a_neg = bus.in_signed & bus.in_a[WIDTH-1];
        b_neg = bus.in_signed & bus.in_b[WIDTH-1];
        // -2^(W-1) maps onto itself, which is its correct unsigned magnitude.
        a_mag_d = a_neg ? (~bus.in_a + WIDTH'(1)) : bus.in_a;
        b_mag_d = b_neg ? (~bus.in_b + WIDTH'(1)) : bus.in_b;
        neg_d   = a_neg ^ b_neg;
    end

    // ------------------------------------------------------------------
    // S2 next-state: partial products
    // ------------------------------------------------------------------
    logic [HP-1:0] p_ll_d, p_lh_d, p_hl_d, p_hh_d;

    always_comb begin
        p_ll_d = vedic_half(a_mag_q[H-1:0],     b_mag_q[H-1:0]);
        p_lh_d = vedic_half(a_mag_q[H-1:0],     b_mag_q[WIDTH-1:H]);
        p_hl_d = vedic_half(a_mag_q[WIDTH-1:H], b_mag_q[H-1:0]);
        p_hh_d = vedic_half(a_mag_q[WIDTH-1:H], b_mag_q[WIDTH-1:H]);
    end

    // ------------------------------------------------------------------
    // S3 next-state: accumulate and apply sign
    // ------------------------------------------------------------------
    logic [PW-1:0] mid_sum, low_sum, mag, prod_d;

    always_comb begin
        // Middle sum is carried at full width so its carry-out is kept.
        mid_sum = ripple_add(zext(p_lh_q), zext(p_hl_q));
        low_sum = ripple_add(zext(p_ll_q), mid_sum << H);
        mag     = ripple_add(low_sum, zext(p_hh_q) << WIDTH);
        // A zero magnitude negates to zero, so no -0 can appear.
        prod_d  = neg2_q ? ripple_add(~mag, PW'(1)) : mag;
    end

    // ------------------------------------------------------------------
    // Registers: everything freezes on stall; data only loads with a valid
    // beat so bubbles leave the previous contents (never X) in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            neg1_q      <= 1'b0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            v2_q        <= 1'b0;
            neg2_q      <= 1'b0;
            p_ll_q      <= '0;
            p_lh_q      <= '0;
            p_hl_q      <= '0;
            p_hh_q      <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (!stall) begin
            v1_q <= in_xfer;
            if (in_xfer) begin
                a_mag_q <= a_mag_d;
                b_mag_q <= b_mag_d;
                neg1_q  <= neg_d;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                p_ll_q <= p_ll_d;
                p_lh_q <= p_lh_d;
                p_hl_q <= p_hl_d;
                p_hh_q <= p_hh_d;
                neg2_q <= neg1_q;
            end

            out_valid_q <= v2_q;
            if (v2_q) begin
                out_p_q <= prod_d;
            end
        end
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
module tb_vedic_mult_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vedic_mult_pipe_if #(.WIDTH(4))  bus4 ();
    vedic_mult_pipe_if #(.WIDTH(8))  bus8 ();
    vedic_mult_pipe_if #(.WIDTH(16)) bus16 ();

    vedic_mult_pipe #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    vedic_mult_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    vedic_mult_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int checks = 0;
    int errors = 0;

    logic [31:0] q4[$];
    logic [31:0] q8[$];
    logic [31:0] q16[$];

    // Reference: plain integer multiply in the selected signedness.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
        longint av, bv, m1, m2;
        m1 = (longint'(1) << w) - 1;
        m2 = (longint'(1) << (2 * w)) - 1;
        av = longint'(a) & m1;
        bv = longint'(b) & m1;
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        return 32'((av * bv) & m2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.in_valid = 0;  bus4.in_a = '0;  bus4.in_b = '0;  bus4.in_signed = 0;
        bus4.out_ready = 1;
        bus8.in_valid = 0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.in_signed = 0;
        bus8.out_ready = 1;
        bus16.in_valid = 0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_signed = 0;
        bus16.out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_all();
        #2;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid8: got %b expected 0", bus8.out_valid);
        end
        checks++;
        if (bus8.out_p !== 16'h0000) begin
            errors++; $display("FAIL reset_out_p8: got %h expected 0000", bus8.out_p);
        end
        checks++;
        if (bus4.out_valid !== 1'b0 || bus16.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid_4_16: got %b %b expected 0 0",
                               bus4.out_valid, bus16.out_valid);
        end
        checks++;
        if (bus16.out_p !== 32'h0) begin
            errors++; $display("FAIL reset_out_p16: got %h expected 0", bus16.out_p);
        end
        tick();
        tick();
        rst = 0;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready8: got %b expected 1", bus8.in_ready);
        end
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_out_valid8: got %b expected 0", bus8.out_valid);
        end
    endtask

    task automatic test_unsigned_basic();
        logic [31:0] want;
        bus8.in_a = 8'd13; bus8.in_b = 8'd11; bus8.in_signed = 0;
        bus8.in_valid = 1; bus8.out_ready = 1;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_in_ready: got %b expected 1", bus8.in_ready);
        end
        q8.push_back(32'h008F);
        tick();                       // edge 1: accept
        bus8.in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (k == 3) begin
                if (bus8.out_valid !== 1'b1) begin
                    errors++; $display("FAIL basic_latency: out_valid %b after edge %0d expected 1",
                                       bus8.out_valid, k);
                end else begin
                    want = q8.pop_front();
                    checks++;
                    if (bus8.out_p !== want[15:0]) begin
                        errors++; $display("FAIL basic_value: got %h expected %h",
                                           bus8.out_p, want[15:0]);
                    end
                end
            end else if (bus8.out_valid !== 1'b0) begin
                errors++; $display("FAIL basic_latency: out_valid %b after edge %0d expected 0",
                                   bus8.out_valid, k);
            end
            tick();
        end
        q8.delete();
    endtask

    task automatic test_unsigned_corner();
        logic [31:0] want;
        bus8.in_signed = 0; bus8.out_ready = 1;
        bus8.in_a = 8'hFF; bus8.in_b = 8'hFF; bus8.in_valid = 1;
        q8.push_back(32'hFE01);
        tick();                       // edge 1
        bus8.in_a = 8'h00; bus8.in_b = 8'hFF;
        q8.push_back(32'h0000);
        tick();                       // edge 2
        bus8.in_valid = 0;
        tick();                       // edge 3
        for (int k = 3; k <= 4; k++) begin
            checks++;
            if (bus8.out_valid !== 1'b1) begin
                errors++; $display("FAIL corner_valid: out_valid %b after edge %0d expected 1",
                                   bus8.out_valid, k);
            end else begin
                want = q8.pop_front();
                checks++;
                if (bus8.out_p !== want[15:0]) begin
                    errors++; $display("FAIL corner_value: got %h expected %h",
                                       bus8.out_p, want[15:0]);
                end
            end
            tick();
        end
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++; $display("FAIL corner_drain: out_valid %b expected 0", bus8.out_valid);
        end
        q8.delete();
    endtask

    task automatic test_signed_corners();
        logic [7:0]  a_tab [4];
        logic [7:0]  b_tab [4];
        logic [15:0] p_tab [4];
        logic [31:0] want;
        a_tab = '{8'h80, 8'hFF, 8'h80, 8'h00};
        b_tab = '{8'h80, 8'h7F, 8'h01, 8'hFB};
        p_tab = '{16'h4000, 16'hFF81, 16'hFF80, 16'h0000};
        bus8.in_signed = 1; bus8.out_ready = 1;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                bus8.in_a = a_tab[k]; bus8.in_b = b_tab[k]; bus8.in_valid = 1;
                q8.push_back({16'h0, p_tab[k]});
            end else begin
                bus8.in_valid = 0;
            end
            tick();                   // edge k+1
            if (k >= 2 && k <= 5) begin
                checks++;
                if (bus8.out_valid !== 1'b1 || q8.size() == 0) begin
                    errors++; $display("FAIL signed_valid: out_valid %b after edge %0d expected 1",
                                       bus8.out_valid, k + 1);
                end else begin
                    want = q8.pop_front();
                    checks++;
                    if (bus8.out_p !== want[15:0]) begin
                        errors++; $display("FAIL signed_value: got %h expected %h",
                                           bus8.out_p, want[15:0]);
                    end
                end
            end
        end
        bus8.in_signed = 0;
        q8.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] p_tab [5];
        logic [31:0] want;
        logic [15:0] held;
        logic        stalled_prev;
        int          sent, got, stall_cycles;
        p_tab = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30};
        sent = 0; got = 0; stall_cycles = 0; stalled_prev = 0; held = '0;
        bus8.in_signed = 0;
        for (int cyc = 1; cyc <= 40 && got < 5; cyc++) begin
            bus8.out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 5) begin
                bus8.in_valid = 1;
                bus8.in_a = 8'(sent + 1);
                bus8.in_b = 8'(sent + 2);
            end else begin
                bus8.in_valid = 0;
            end
            @(negedge clk);
            if (bus8.out_valid && !bus8.out_ready) begin
                stall_cycles++;
                checks++;
                if (bus8.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b expected 0", bus8.in_ready);
                end
                if (stalled_prev) begin
                    checks++;
                    if (bus8.out_p !== held) begin
                        errors++; $display("FAIL bp_hold: got %h expected %h", bus8.out_p, held);
                    end
                end
                stalled_prev = 1;
                held = bus8.out_p;
            end else begin
                stalled_prev = 0;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h expected none", bus8.out_p);
                end else begin
                    want = q8.pop_front();
                    if (bus8.out_p !== want[15:0]) begin
                        errors++; $display("FAIL bp_order: got %h expected %h",
                                           bus8.out_p, want[15:0]);
                    end
                end
                got++;
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back({16'h0, p_tab[sent]});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus8.in_valid = 0; bus8.out_ready = 1;
        checks++;
        if (got != 5 || q8.size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d products expected 5", got);
        end
        checks++;
        if (stall_cycles != 4) begin
            errors++; $display("FAIL bp_stall_len: got %0d stall cycles expected 4", stall_cycles);
        end
        tick();
        tick();
        q8.delete();
    endtask

    task automatic test_reset_midstream();
        logic [31:0] want;
        int          seen;
        bus8.in_signed = 0; bus8.out_ready = 1;
        bus8.in_a = 8'd5; bus8.in_b = 8'd7; bus8.in_valid = 1;
        tick();
        bus8.in_a = 8'd6;
        tick();
        bus8.in_valid = 0;
        rst = 1;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_p !== 16'h0000) begin
            errors++; $display("FAIL midrst_clear: got valid %b p %h expected 0 0000",
                               bus8.out_valid, bus8.out_p);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.out_p !== 16'h0000) begin
            errors++; $display("FAIL midrst_hold: got valid %b p %h expected 0 0000",
                               bus8.out_valid, bus8.out_p);
        end
        rst = 0;
        q8.delete();
        bus8.in_a = 8'd3; bus8.in_b = 8'd3; bus8.in_valid = 1;
        q8.push_back(32'd9);
        tick();                       // edge 1: accept
        bus8.in_valid = 0;
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus8.out_valid) begin
                seen++;
                checks++;
                if (k != 3) begin
                    errors++; $display("FAIL midrst_latency: product after edge %0d expected 3", k);
                end
                if (q8.size() == 0) begin
                    errors++; $display("FAIL midrst_extra: got %h expected none", bus8.out_p);
                end else begin
                    want = q8.pop_front();
                    checks++;
                    if (bus8.out_p !== want[15:0]) begin
                        errors++; $display("FAIL midrst_value: got %h expected %h",
                                           bus8.out_p, want[15:0]);
                    end
                end
            end
            tick();
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL midrst_count: got %0d products expected 1", seen);
        end
        q8.delete();
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [31:0] want;
        int s4, s8, s16, g4, g8, g16;
        s4 = 0; s8 = 0; s16 = 0; g4 = 0; g8 = 0; g16 = 0;
        q4.delete(); q8.delete(); q16.delete();
        for (int cyc = 0; cyc < 40000 && !(g4 == N && g8 == N && g16 == N); cyc++) begin
            bus4.in_valid  = (s4 < N)  && ($urandom_range(0, 3) != 0);
            bus4.in_a      = 4'($urandom);  bus4.in_b  = 4'($urandom);
            bus4.in_signed = 1'($urandom);  bus4.out_ready = ($urandom_range(0, 3) != 0);
            bus8.in_valid  = (s8 < N)  && ($urandom_range(0, 3) != 0);
            bus8.in_a      = 8'($urandom);  bus8.in_b  = 8'($urandom);
            bus8.in_signed = 1'($urandom);  bus8.out_ready = ($urandom_range(0, 3) != 0);
            bus16.in_valid = (s16 < N) && ($urandom_range(0, 3) != 0);
            bus16.in_a     = 16'($urandom); bus16.in_b = 16'($urandom);
            bus16.in_signed = 1'($urandom); bus16.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus4.out_valid && bus4.out_ready) begin
                checks++; g4++;
                if (q4.size() == 0) begin
                    errors++; $display("FAIL rand4_extra: got %h expected none", bus4.out_p);
                end else begin
                    want = q4.pop_front();
                    if (bus4.out_p !== want[7:0]) begin
                        errors++; $display("FAIL rand4_value: got %h expected %h",
                                           bus4.out_p, want[7:0]);
                    end
                end
            end
            if (bus8.out_valid && bus8.out_ready) begin
                checks++; g8++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL rand8_extra: got %h expected none", bus8.out_p);
                end else begin
                    want = q8.pop_front();
                    if (bus8.out_p !== want[15:0]) begin
                        errors++; $display("FAIL rand8_value: got %h expected %h",
                                           bus8.out_p, want[15:0]);
                    end
                end
            end
            if (bus16.out_valid && bus16.out_ready) begin
                checks++; g16++;
                if (q16.size() == 0) begin
                    errors++; $display("FAIL rand16_extra: got %h expected none", bus16.out_p);
                end else begin
                    want = q16.pop_front();
                    if (bus16.out_p !== want) begin
                        errors++; $display("FAIL rand16_value: got %h expected %h",
                                           bus16.out_p, want);
                    end
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                q4.push_back(ref_mul(4, 16'(bus4.in_a), 16'(bus4.in_b), bus4.in_signed));
                s4++;
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(ref_mul(8, 16'(bus8.in_a), 16'(bus8.in_b), bus8.in_signed));
                s8++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q16.push_back(ref_mul(16, bus16.in_a, bus16.in_b, bus16.in_signed));
                s16++;
            end
            @(posedge clk);
            #1;
        end
        idle_all();
        checks++;
        if (g4 != N || g8 != N || g16 != N) begin
            errors++; $display("FAIL rand_count: got %0d/%0d/%0d products expected %0d each",
                               g4, g8, g16, N);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_corner();
        test_signed_corners();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined N×N Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready stream interface.
- Generalises the fixed 4-bit combinational Vedic multiplier:
  - WIDTH is configurable.
  - Signed or unsigned operation is selected per transaction.
  - Throughput is one product per cycle, with fixed 3-cycle latency and full backpressure.
- Sits between an operand source and any downstream consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand width. Must be a power of 2 and ≥ 4. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  output  1  out_p holds a valid product.
- out_ready  input  1  consumer accepts product.
- out_p  output  2*WIDTH  product.

Behaviour:
- Reset (async assert, sync-released use):
  - out_valid = 0, out_p = 0, all stage valid bits = 0, all pipeline data registers = 0.
  - in_ready = 1 once reset is deasserted.
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a rising clk.
  - Output transfer occurs when out_valid & out_ready at a rising clk.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall is high, every pipeline register, including out_p, holds its value.
  - out_p must stay stable while out_valid is high and out_ready is low.
- Stage 1 (S1, capture):
  - On transfer, register |a| and |b| as WIDTH-bit magnitudes.
  - Register neg = in_signed & (a[W-1] ^ b[W-1]).
  - Register v1 = 1.
  - If not stalled and there is no transfer, v1 = 0 (bubble).
  - Magnitude of the most negative value (-2^(W-1)) is 2^(W-1) and is representable unsigned.
- Stage 2 (S2, partial products):
  - Split magnitudes into H = WIDTH/2 halves: aL, aH, bL, bH.
  - Register four H×H products: pLL = aL*bL, pLH = aL*bH, pHL = aH*bL, pHH = aH*bH.
  - Each product is 2H bits wide.
  - Sub-products are formed by recursive Vedic decomposition down to 2×2 cells (AND/half-adder). The behavioural `*` operator is not permitted.
  - Propagate neg and v2 = v1.
- Stage 3 (S3, accumulate):
  - Compute mag = pLL + (pLH + pHL) << H + pHH << WIDTH.
  - Use ripple-carry adders.
  - The middle sum keeps its carry-out (2H+1 bits); no overflow is possible in 2*WIDTH bits.
  - out_p = neg ? (~mag + 1) : mag.
  - out_valid = v2.
- Latency and throughput:
  - Latency is exactly 3 rising edges from input transfer to out_valid = 1, when not stalled.
  - Throughput is 1 beat per cycle when out_ready = 1 continuously.
  - Zero-operand products with neg set yield 0. Two's complement of 0 is 0, so no -0 artefact.
- Bubbles:
  - A bubble reaching S3 drives out_valid = 0.
  - out_p keeps its last value; it is don't-care for the consumer but must not go X.
- Ordering: products emerge in acceptance order. No reordering, no drop, no duplication.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are legal.
  - Because stall = 0 whenever out_ready = 1, the pipeline advances and a full pipe loses no beat.
- Reset mid-operation:
  - Asserting rst immediately clears all valid bits and data.
  - In-flight products are discarded.
  - After release, the first accepted beat appears 3 cycles later.

Test Plan (WIDTH = 8 unless noted):
1. Unsigned basic:
   - Stimulus: a = 13, b = 11, signed = 0, out_ready = 1.
   - Response: out_valid rises exactly 3 edges after accept; out_p = 0x008F.
2. Unsigned corner:
   - Stimulus: a = 0xFF, b = 0xFF, then a = 0, b = 0xFF.
   - Response: out_p = 0xFE01, then 0x0000, on consecutive cycles.
3. Signed corners:
   - Stimulus: (-128)×(-128), then (-1)×127, then (-128)×1, all with signed = 1.
   - Response: out_p = 0x4000, then 0xFF81, then 0xFF80.
4. Backpressure:
   - Stimulus: stream 5 beats (k, k+1) for k = 1..5, with out_ready held low for cycles 4–7.
   - Response:
     - in_ready = 0 during the stall.
     - out_p is stable while stalled.
     - All 5 products (2, 6, 12, 20, 30) are delivered in order with no loss or duplicates.
5. Reset mid-stream:
   - Stimulus: accept 2 beats, assert rst for 1 cycle before either emerges, then accept 3×3.
   - Response:
     - out_valid = 0 and out_p = 0 during reset.
     - The only product seen is 9, arriving 3 edges after its accept.
6. Random regression:
   - Stimulus: WIDTH = 4, 8 and 16, 10k random beats, random in_valid/out_ready, random signed mode.
   - Response: every out_p matches the reference model a*b in the selected signedness, in order.
